// File: rtl/mult_sched_pkg.sv
// Shared defaults, tag record and width helper for the multiplier scheduler.
package mult_sched_pkg;
   localparam int DEF_N       = 4;
   localparam int DEF_W       = 3;
   localparam int DEF_MUL_LAT = 2;
   // Tag ID sized for the largest supported N (8); narrower IDs zero-extend.
   localparam int MAX_IDW     = 3;

   typedef struct packed {
      logic               vld;
      logic [MAX_IDW-1:0] id;
   } tag_t;

   function automatic int prod_w(input int w);
      return 2 * w;
   endfunction
endpackage

// File: rtl/mult_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner, pointer moves only on handshake.
module rr_arbiter #(
   parameter  int N   = 4,
   localparam int IDW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic           en,
   input  logic           advance,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] idx
);
   logic [IDW-1:0] r_ptr;
   logic           w_found;
   int             w_j;

   always_comb begin
      gnt     = '0;
      idx     = '0;
      w_found = 1'b0;
      w_j     = 0;
      for (int k = 1; k <= N; k++) begin
         w_j = (int'(r_ptr) + k) % N;
         if (!w_found && req[w_j]) begin
            w_found  = 1'b1;
            gnt[w_j] = en;
            idx      = w_j[IDW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_ptr <= IDW'(N - 1);
      else if (advance) r_ptr <= idx;
   end
endmodule

// File: rtl/mult_scheduler.sv
// Time-shares one fixed-latency multiplier between N requesters, tagging each
// issue with its requester ID so the product can be routed back in order.
module mult_scheduler
   import mult_sched_pkg::*;
#(
   parameter  int N       = DEF_N,
   parameter  int W       = DEF_W,
   parameter  int MUL_LAT = DEF_MUL_LAT,
   localparam int IDW     = $clog2(N),
   localparam int PW      = prod_w(W)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic [N-1:0]   req_valid,
   input  logic [N*W-1:0] req_a,
   input  logic [N*W-1:0] req_b,
   output logic [N-1:0]   req_ready,
   output logic [W-1:0]   mul_a,
   output logic [W-1:0]   mul_b,
   input  logic [PW-1:0]  mul_y,
   output logic           rsp_valid,
   output logic [IDW-1:0] rsp_id,
   output logic [PW-1:0]  rsp_y,
   output logic           busy
);
   logic [N-1:0]   w_gnt;
   logic [IDW-1:0] w_idx;
   logic           w_hs;
   logic           w_busy;
   tag_t           w_new_tag;

   logic [W-1:0]   r_mul_a, r_mul_b;
   logic           r_rsp_valid;
   logic [IDW-1:0] r_rsp_id;
   logic [PW-1:0]  r_rsp_y;
   tag_t           r_tag [MUL_LAT];

   rr_arbiter #(.N(N)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_valid),
      .en      (en),
      .advance (w_hs),
      .gnt     (w_gnt),
      .idx     (w_idx)
   );

   assign req_ready = w_gnt;
   assign w_hs      = |(req_valid & w_gnt);

   always_comb begin
      w_new_tag     = '0;
      w_new_tag.vld = w_hs;
      w_new_tag.id  = w_hs ? MAX_IDW'(w_idx) : '0;
   end

   // Idle cycles drive zero operands so the multiplier never sees stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mul_a     <= '0;
         r_mul_b     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_y     <= '0;
         for (int s = 0; s < MUL_LAT; s++) r_tag[s] <= '0;
      end else begin
         r_mul_a  <= w_hs ? req_a[w_idx*W +: W] : '0;
         r_mul_b  <= w_hs ? req_b[w_idx*W +: W] : '0;
         r_tag[0] <= w_new_tag;
         for (int s = 1; s < MUL_LAT; s++) r_tag[s] <= r_tag[s-1];
         r_rsp_valid <= r_tag[MUL_LAT-1].vld;
         if (r_tag[MUL_LAT-1].vld) begin
            r_rsp_y  <= mul_y;
            r_rsp_id <= r_tag[MUL_LAT-1].id[IDW-1:0];
         end
      end
   end

   always_comb begin
      w_busy = r_rsp_valid;
      for (int s = 0; s < MUL_LAT; s++) w_busy = w_busy | r_tag[s].vld;
   end

   assign mul_a     = r_mul_a;
   assign mul_b     = r_mul_b;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_y     = r_rsp_y;
   assign busy      = w_busy;
endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench: per-cycle vector tables plus hand-written arbitration, enable and reset sequences.
module tb_mult_scheduler;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [11:0] req_a = '0, req_b = '0;
   logic [3:0]  req_ready;
   logic [2:0]  mul_a, mul_b;
   logic [5:0]  mul_y;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [5:0]  rsp_y;
   logic        busy;
   logic [5:0]  m_y;

   int n_chk = 0, n_pass = 0;

   typedef struct {
      logic        en;
      logic [3:0]  rv;
      logic [11:0] a, b;
      logic [3:0]  rdy;
      logic [2:0]  ma, mb;
      logic        rspv;
      logic [1:0]  id;
      logic [5:0]  y;
      logic        bsy;
   } vec_t;
   vec_t vq[$];

   localparam logic [11:0] A4 = 12'd2257;  // {4,3,2,1}
   localparam logic [11:0] B7 = 12'd4095;  // {7,7,7,7}

   mult_scheduler dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy)
   );

   always #5 clk = ~clk;

   // Two-cycle multiplier: mul_a register plus one product register.
   always @(posedge clk) m_y <= {3'b000, mul_a} * {3'b000, mul_b};
   assign mul_y = m_y;

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic apply_vecs(input string tag);
      for (int k = 0; k < vq.size(); k++) begin
         step();
         en = vq[k].en; req_valid = vq[k].rv; req_a = vq[k].a; req_b = vq[k].b;
         #1;
         chk($sformatf("%s[%0d].ready", tag, k), req_ready, vq[k].rdy);
         chk($sformatf("%s[%0d].mul_a", tag, k), mul_a, vq[k].ma);
         chk($sformatf("%s[%0d].mul_b", tag, k), mul_b, vq[k].mb);
         chk($sformatf("%s[%0d].rsp_valid", tag, k), rsp_valid, vq[k].rspv);
         chk($sformatf("%s[%0d].rsp_id", tag, k), rsp_id, vq[k].id);
         chk($sformatf("%s[%0d].rsp_y", tag, k), rsp_y, vq[k].y);
         chk($sformatf("%s[%0d].busy", tag, k), busy, vq[k].bsy);
      end
      vq.delete();
   endtask

   initial begin
      logic [3:0] fexp [8];
      logic [3:0] erdy [8];
      logic [2:0] ema  [8];
      logic       ersp [8];

      // Reset state
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst.mul_a", mul_a, 0);
      chk("rst.mul_b", mul_b, 0);
      chk("rst.rsp_valid", rsp_valid, 0);
      chk("rst.rsp_id", rsp_id, 0);
      chk("rst.rsp_y", rsp_y, 0);
      chk("rst.busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single request: 3*5
      vq.push_back(vec_t'{1'b1, 4'b0001, 12'd3, 12'd5, 4'b0001, 3'd0, 3'd0, 1'b0, 2'd0, 6'd0, 1'b0});
      vq.push_back(vec_t'{1'b1, 4'b0000, 12'd0, 12'd0, 4'b0000, 3'd3, 3'd5, 1'b0, 2'd0, 6'd0, 1'b1});
      vq.push_back(vec_t'{1'b1, 4'b0000, 12'd0, 12'd0, 4'b0000, 3'd0, 3'd0, 1'b0, 2'd0, 6'd0, 1'b1});
      vq.push_back(vec_t'{1'b1, 4'b0000, 12'd0, 12'd0, 4'b0000, 3'd0, 3'd0, 1'b1, 2'd0, 6'd15, 1'b1});
      vq.push_back(vec_t'{1'b1, 4'b0000, 12'd0, 12'd0, 4'b0000, 3'd0, 3'd0, 1'b0, 2'd0, 6'd15, 1'b0});
      apply_vecs("single");

      // Four simultaneous requests, each dropping once granted
      do_reset();
      vq.push_back(vec_t'{1'b1, 4'b1111, A4, B7, 4'b0001, 3'd0, 3'd0, 1'b0, 2'd0, 6'd0, 1'b0});
      vq.push_back(vec_t'{1'b1, 4'b1110, A4, B7, 4'b0010, 3'd1, 3'd7, 1'b0, 2'd0, 6'd0, 1'b1});
      vq.push_back(vec_t'{1'b1, 4'b1100, A4, B7, 4'b0100, 3'd2, 3'd7, 1'b0, 2'd0, 6'd0, 1'b1});
      vq.push_back(vec_t'{1'b1, 4'b1000, A4, B7, 4'b1000, 3'd3, 3'd7, 1'b1, 2'd0, 6'd7, 1'b1});
      vq.push_back(vec_t'{1'b1, 4'b0000, A4, B7, 4'b0000, 3'd4, 3'd7, 1'b1, 2'd1, 6'd14, 1'b1});
      vq.push_back(vec_t'{1'b1, 4'b0000, A4, B7, 4'b0000, 3'd0, 3'd0, 1'b1, 2'd2, 6'd21, 1'b1});
      vq.push_back(vec_t'{1'b1, 4'b0000, A4, B7, 4'b0000, 3'd0, 3'd0, 1'b1, 2'd3, 6'd28, 1'b1});
      vq.push_back(vec_t'{1'b1, 4'b0000, A4, B7, 4'b0000, 3'd0, 3'd0, 1'b0, 2'd3, 6'd28, 1'b0});
      apply_vecs("four");

      // Fairness: 0 and 2 held, 1 joins at cycle 3
      do_reset();
      fexp = '{4'b0001, 4'b0100, 4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100};
      for (int t = 0; t < 8; t++) begin
         step();
         en = 1'b1; req_valid = {1'b0, 1'b1, (t >= 3), 1'b1}; req_a = A4; req_b = B7;
         #1;
         chk($sformatf("fair[%0d].ready", t), req_ready, fexp[t]);
      end
      req_valid = '0;
      for (int t = 0; t < 5; t++) step();

      // en low in cycles 2-4 with everyone requesting
      do_reset();
      erdy = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0001};
      ema  = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd3, 3'd4};
      ersp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int t = 0; t < 8; t++) begin
         step();
         en = !(t >= 2 && t <= 4); req_valid = 4'hF; req_a = A4; req_b = B7;
         #1;
         chk($sformatf("en[%0d].ready", t), req_ready, erdy[t]);
         chk($sformatf("en[%0d].mul_a", t), mul_a, ema[t]);
         chk($sformatf("en[%0d].rsp_valid", t), rsp_valid, ersp[t]);
         if (t == 3) begin
            chk("en[3].rsp_id", rsp_id, 0);
            chk("en[3].rsp_y", rsp_y, 7);
         end
         if (t == 4) begin
            chk("en[4].rsp_id", rsp_id, 1);
            chk("en[4].rsp_y", rsp_y, 14);
         end
      end
      req_valid = '0;
      for (int t = 0; t < 6; t++) step();

      // Boundary product 7*7 on requester 3
      step();
      en = 1'b1; req_valid = 4'b1000; req_a = 12'd7 << 9; req_b = 12'd7 << 9;
      #1;
      chk("max.ready", req_ready, 4'b1000);
      step();
      req_valid = '0;
      #1;
      chk("max.mul_a", mul_a, 7);
      chk("max.mul_b", mul_b, 7);
      step();
      step();
      chk("max.rsp_valid", rsp_valid, 1);
      chk("max.rsp_id", rsp_id, 3);
      chk("max.rsp_y", rsp_y, 49);
      for (int t = 0; t < 3; t++) step();

      // Reset mid-flight after a handshake from requester 2
      step();
      req_valid = 4'b0100; req_a = 12'd5 << 6; req_b = 12'd6 << 6;
      #1;
      chk("rmf.ready", req_ready, 4'b0100);
      step();
      req_valid = '0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rmf.mul_a", mul_a, 0);
      chk("rmf.busy", busy, 0);
      #1;
      rst_n = 1'b1;
      for (int t = 0; t < 4; t++) begin
         step();
         chk($sformatf("rmf.rsp_valid[%0d]", t), rsp_valid, 0);
      end
      step();
      en = 1'b1; req_valid = 4'b1001;
      #1;
      chk("rmf.first_grant", req_ready, 4'b0001);
      step();
      req_valid = '0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
